// File: rtl/dvi_frame_writer.sv
// DVI capture stage: thresholds 8-bit luminance to 1 bit, packs 8 pixels/byte MSB-first, writes
// bytes to the frame buffer. Optional ordered dither enabled by defining DVI_WRITER_DITHER_EN.
module dvi_frame_writer #(
  parameter logic [13:0] screenWidth  = 14'h0050,
  parameter logic [13:0] screenHeight = 14'h00F0,
  parameter logic [7:0]  threshold    = 8'h80
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        vsIn,
  input  logic        hsIn,
  input  logic        deIn,
  input  logic [7:0]  pixIn,
  output logic [14:0] addr,
  output logic [7:0]  wrData,
  output logic        wrEn,
  output logic        frameDone
);

  typedef enum logic [1:0] {StWaitVs, StActive, StDone} state_t;

  state_t      state;
  logic        vsPrev;
  logic        inLine;
  logic [2:0]  bitCnt;
  logic [6:0]  byteX;
  logic [7:0]  lineY;
  logic [7:0]  shiftReg;
  logic        pend;
  logic [7:0]  pendData;
  logic [14:0] pendAddr;

  logic        vsRise;
  logic        pixBit;
  logic        roomLeft;
  logic [14:0] curAddr;
  logic        unusedHs;

  assign unusedHs = hsIn;
  assign vsRise   = vsIn && !vsPrev;
  assign roomLeft = {7'b0, byteX} < screenWidth;
  assign curAddr  = 15'(byteX) + 15'(lineY) * 15'(screenWidth);

`ifdef DVI_WRITER_DITHER_EN
  logic signed [9:0] ditherOff;
  logic signed [9:0] effThr;

  always_comb begin
    ditherOff = 10'sd0;
    unique case ({lineY[0], bitCnt[0]})
      2'b00: ditherOff = -10'sd48;
      2'b01: ditherOff = 10'sd16;
      2'b10: ditherOff = 10'sd48;
      2'b11: ditherOff = -10'sd16;
      default: ditherOff = 10'sd0;
    endcase
  end

  assign effThr = $signed({2'b00, threshold}) + ditherOff;
  assign pixBit = $signed({2'b00, pixIn}) >= effThr;
`else
  assign pixBit = pixIn >= threshold;
`endif

  // Byte completion is staged in pend* so every write appears one cycle after its trigger.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state     <= StWaitVs;
      vsPrev    <= 1'b0;
      inLine    <= 1'b0;
      bitCnt    <= 3'd0;
      byteX     <= 7'd0;
      lineY     <= 8'd0;
      shiftReg  <= 8'd0;
      pend      <= 1'b0;
      pendData  <= 8'd0;
      pendAddr  <= 15'd0;
      addr      <= 15'd0;
      wrData    <= 8'd0;
      wrEn      <= 1'b0;
      frameDone <= 1'b0;
    end else begin
      vsPrev    <= vsIn;
      wrEn      <= pend;
      frameDone <= 1'b0;
      pend      <= 1'b0;
      if (pend) begin
        addr   <= pendAddr;
        wrData <= pendData;
      end
      unique case (state)
        StWaitVs: begin
          if (vsRise) begin
            state    <= StActive;
            inLine   <= 1'b0;
            bitCnt   <= 3'd0;
            byteX    <= 7'd0;
            lineY    <= 8'd0;
            shiftReg <= 8'd0;
          end
        end
        StActive: begin
          if (vsRise) begin
            inLine   <= 1'b0;
            bitCnt   <= 3'd0;
            byteX    <= 7'd0;
            lineY    <= 8'd0;
            shiftReg <= 8'd0;
          end else if (deIn) begin
            inLine <= 1'b1;
            if (roomLeft) begin
              bitCnt <= bitCnt + 3'd1;
              if (bitCnt == 3'd7) begin
                pend     <= 1'b1;
                pendData <= {shiftReg[6:0], pixBit};
                pendAddr <= curAddr;
                byteX    <= byteX + 7'd1;
                shiftReg <= 8'd0;
              end else begin
                shiftReg <= {shiftReg[6:0], pixBit};
              end
            end
          end else if (inLine) begin
            inLine <= 1'b0;
            if (bitCnt != 3'd0) begin
              // Left-justify the partial byte, zero-filling the unused low bits.
              pend     <= 1'b1;
              pendData <= shiftReg << (4'd8 - {1'b0, bitCnt});
              pendAddr <= curAddr;
            end
            bitCnt   <= 3'd0;
            byteX    <= 7'd0;
            shiftReg <= 8'd0;
            lineY    <= lineY + 8'd1;
            if (14'(lineY) + 14'd1 == screenHeight) state <= StDone;
          end
        end
        StDone: begin
          frameDone <= 1'b1;
          state     <= StWaitVs;
        end
        default: state <= StWaitVs;
      endcase
    end
  end

endmodule
